sram_prog_loader: RTL
=====================

// Module: sram_prog_loader
// PURPOSE
//  Boot-time program loader. After a start pulse it walks the external SRAM from
//  BASE_ADDR, reads 16-bit program words and pushes them with a valid/ready
//  handshake into the scheduler's instruction store (write port wr_*).
//  Sits between the SRAM pins (data_input/input_addr/mem_*) and the scheduler.
//  Cores stay idle until done is asserted.
// PARAMETERS
//  ADDR_W     20       SRAM address width
//  DATA_W     16       SRAM / instruction word width
//  PROG_WORDS 1024     max words loaded; wr_addr width = $clog2(PROG_WORDS)
//  BASE_ADDR  20'h0    first SRAM address read
//  RD_LAT     2        SRAM access wait cycles, >=1
//  END_WORD   16'hFFFF terminator word; written, then load stops
// PORTS
//  clk          in   1       system clock (CLOCK_50)
//  reset        in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse: begin load; ignored while busy
//  data_input   in   DATA_W  SRAM read data (DQ)
//  input_addr   out  ADDR_W  SRAM address
//  mem_cen      out  1       SRAM chip enable, active low
//  mem_oen      out  1       SRAM output enable, active low
//  wr_valid     out  1       instruction word valid to scheduler
//  wr_addr      out  10      instruction store index (log2 PROG_WORDS)
//  wr_data      out  DATA_W  instruction word
//  wr_ready     in   1       scheduler accepts word when wr_valid&wr_ready
//  busy         out  1       load in progress
//  done         out  1       load complete; held until next accepted start/reset
//  word_count   out  11      words accepted in current/last load (0..PROG_WORDS)
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE; input_addr=BASE_ADDR; mem_cen=mem_oen=1;
//   wr_valid=0; wr_addr=0; wr_data=0; busy=0; done=0; word_count=0. Reset
//   mid-load aborts; no further wr_valid; partial store contents not cleared.
//  FSM: IDLE -> ADDR -> WAIT -> PUSH -> (ADDR | DONE); DONE -> ADDR on start.
//  IDLE/DONE: start=1 -> ADDR next cycle; input_addr=BASE_ADDR, wr_addr=0,
//   word_count=0, done=0, busy=1 all registered on that edge.
//  ADDR (1 cycle): mem_cen=mem_oen=0, input_addr stable.
//  WAIT (RD_LAT cycles, counter 0..RD_LAT-1): cen/oen stay low; on last cycle
//   data_input registered into wr_data; next state PUSH.
//  PUSH: wr_valid=1, wr_data/wr_addr stable until handshake; cen/oen=1.
//   On wr_valid&wr_ready: word_count+1; if word==END_WORD or
//   word_count+1==PROG_WORDS -> DONE; else input_addr+1, wr_addr+1 -> ADDR.
//  Throughput: RD_LAT+2 cycles/word with wr_ready=1; done rises 1 cycle after
//   last handshake. wr_ready low stalls PUSH indefinitely, no data change.
//  DONE: busy=0, done=1, wr_valid=0, cen/oen=1.
//  input_addr increments modulo 2^ADDR_W (wraps, no error); wr_addr never
//   exceeds PROG_WORDS-1 by PROG_WORDS limit.
//  start while busy: ignored. start and reset same cycle: reset wins.
//  No combinational path from any input to any output.
// TESTING
//  1 SRAM model 0x1000+i, END_WORD absent, PROG_WORDS=8, RD_LAT=2, wr_ready=1,
//    start pulse -> 8 writes addr 0..7 data 0x1000..0x1007, 4 cyc apart, done
//    1 cyc after 8th, word_count=8.
//  2 word 3 = 0xFFFF -> writes addr 0..3 (last data 0xFFFF), done, count=4.
//  3 wr_ready low 5 cyc during word 1 -> wr_valid/wr_data/wr_addr held stable,
//    total load +5 cycles, no lost/duplicated words.
//  4 reset asserted in WAIT of word 2 -> next cycle all outputs at reset
//    values; later start reloads from addr 0 cleanly.
//  5 start pulses while busy and in same cycle as reset -> ignored; second
//    start after done -> done drops, full reload, count restarts at 0.
//  6 BASE_ADDR=20'hFFFFE, 4 words -> input_addr FFFFE,FFFFF,00000,00001.

Source files
------------

// File: rtl/sram_prog_loader.sv
// sram_prog_loader: boot-time loader that copies SRAM words into the scheduler instruction store
//   clk, reset         : system clock, synchronous active-high reset
//   start              : one-cycle pulse that begins a load (ignored while busy)
//   data_input         : SRAM read data
//   input_addr         : SRAM address
//   mem_cen, mem_oen   : SRAM chip/output enable, active low
//   wr_valid, wr_ready : valid/ready handshake to the instruction store
//   wr_addr, wr_data   : instruction store index and word
//   busy, done         : load in progress / load complete (held until restart or reset)
//   word_count         : words accepted in the current or last load
module sram_prog_loader #(
  parameter int                 ADDR_W     = 20,
  parameter int                 DATA_W     = 16,
  parameter int                 PROG_WORDS = 1024,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
  parameter int                 RD_LAT     = 2,
  parameter logic [DATA_W-1:0]  END_WORD   = '1,
  localparam int                PW_W       = $clog2(PROG_WORDS),
  localparam int                CNT_W      = PW_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_input,
  output logic [ADDR_W-1:0] input_addr,
  output logic              mem_cen,
  output logic              mem_oen,
  output logic              wr_valid,
  output logic [PW_W-1:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count
);
  localparam int LW = $clog2(RD_LAT + 1);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, PUSH, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW_W-1:0]   wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [CNT_W-1:0]  cnt_inc;
  // the store is full once this handshake brings the count to PROG_WORDS
  logic              last;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign last    = (wd_q == END_WORD) || (cnt_inc == CNT_W'(PROG_WORDS));
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = ADDR;
        addr_d  = BASE_ADDR;
        wa_d    = '0;
        cnt_d   = '0;
      end
      ADDR: begin
        state_d = WAIT;
        lat_d   = '0;
      end
      WAIT: begin
        lat_d = lat_q + LW'(1);
        if (lat_q == LW'(RD_LAT - 1)) begin
          wd_d    = data_input;
          state_d = PUSH;
        end
      end
      PUSH: if (wr_ready) begin
        cnt_d   = cnt_inc;
        state_d = last ? DONE : ADDR;
        addr_d  = last ? addr_q : addr_q + ADDR_W'(1);
        wa_d    = last ? wa_q : wa_q + PW_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      wa_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end
  // every output is a register or a decode of the state register only
  assign input_addr = addr_q;
  assign mem_cen    = !(state_q == ADDR || state_q == WAIT);
  assign mem_oen    = !(state_q == ADDR || state_q == WAIT);
  assign wr_valid   = state_q == PUSH;
  assign wr_addr    = wa_q;
  assign wr_data    = wd_q;
  assign busy       = state_q == ADDR || state_q == WAIT || state_q == PUSH;
  assign done       = state_q == DONE;
  assign word_count = cnt_q;
endmodule
